dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the pipeline CPU's load/store interface.
- Accepts one word load/store request at a time over a valid/ready request channel. Returns completion on a valid/ready response channel after a fixed configurable latency.
- Sits between the CPU MEM stage (or a stall-capable wrapper around it) and on-chip word storage. It replaces the single-cycle data memory where realistic access latency must be modelled.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two, ≥ 2.
- LATENCY, 2, cycles from request acceptance to resp_valid; integer ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response this cycle.
- resp_rdata  out  32  load data; 0 for stores.
- resp_err  out  1  access error; see Optional Feature.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - State goes to IDLE.
  - req_ready=1 after the reset cycle; resp_valid=0, resp_rdata=0, resp_err=0.
  - Wait counter cleared; every storage word cleared to 0.
- Word index = req_addr[1+log2(DEPTH_WORDS):2]. Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4. req_addr[1:0] is ignored unless the feature is enabled.
- State IDLE:
  - req_ready=1.
  - Handshake = req_valid & req_ready at a rising edge.
  - On handshake: capture req_write, index, req_wdata; load counter with LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
- State WAIT:
  - req_ready=0; counter decrements by 1 each cycle.
  - At the edge where counter==1, commit the access and enter RESP.
- Commit, performed on the edge entering RESP:
  - Store: write mem[index]=wdata; resp_rdata=0.
  - Load: resp_rdata=mem[index].
- State RESP:
  - resp_valid=1; req_ready=0.
  - resp_rdata and resp_err are held stable until resp_ready=1 at an edge.
  - On resp_ready: return to IDLE with resp_valid=0 and resp_rdata held at its last value.
- Latency:
  - Request accepted at edge N gives resp_valid high from edge N+LATENCY.
  - Minimum spacing between consecutive acceptances = LATENCY+1 cycles. The IDLE cycle after a response handshake is mandatory: no same-cycle response-retire plus new accept.
- Request inputs are ignored whenever req_ready=0. resp_ready is ignored outside RESP.
- Load after store to the same index returns the stored value; commits are strictly in order.
- Reset mid-operation:
  - rst in WAIT before the commit edge: the store is discarded and memory is cleared anyway.
  - rst in RESP: the response is dropped.
  - rst has priority over every other event in the same cycle.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - At acceptance, req_addr[1:0]!=0 flags the request misaligned.
  - At commit, a misaligned store does not write memory and a misaligned load returns resp_rdata=0.
  - resp_err=1 for that response; timing is unchanged.
- Undefined:
  - resp_err is tied 0.
  - Low address bits are ignored; the access proceeds on the word index.

Test Plan:
- LATENCY=2: store addr 0x10 data 0xDEADBEEF accepted at edge 0 -> resp_valid at edge 2, resp_rdata=0. Then load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_rdata stay constant, req_ready=0 throughout. Raise resp_ready -> IDLE next cycle, req_ready=1.
- Aliasing, DEPTH_WORDS=256: store 0x12345678 to 0x0000_0004, then load 0x0000_0404 -> 0x12345678.
- Reset mid-op: store 0xAAAA5555 to 0x20 and assert rst in the WAIT cycle -> resp_valid never rises, req_ready=1 after reset. Then load 0x20 -> 0.
- LATENCY=1 with back-to-back requests and resp_ready held 1: req_valid held 1 with two loads -> acceptances exactly 2 cycles apart, each resp_valid exactly 1 cycle after its acceptance.
- With DMEM_ALIGN_CHECK_EN: store 0xFFFFFFFF to 0x22 -> resp_err=1. Then load 0x20 -> 0, resp_err=0. Without the macro, the same store -> resp_err=0 and a load from 0x20 returns 0xFFFFFFFF.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle word data-memory responder: valid/ready request in, valid/ready response out after LATENCY cycles.
// Optional misaligned-access checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [DATA_W-1:0]         r_mem [DEPTH_WORDS];

  logic                      r_write;
  logic [IDX_W-1:0]          r_idx;
  logic [DATA_W-1:0]         r_wdata;
  logic                      r_mis;
  logic [DATA_W-1:0]         r_rdata;
  logic                      r_err;

  logic                      w_accept;
  logic                      w_commit;
  logic [IDX_W-1:0]          w_req_idx;
  logic                      w_req_mis;
  logic                      w_c_write;
  logic [IDX_W-1:0]          w_c_idx;
  logic [DATA_W-1:0]         w_c_wdata;
  logic                      w_c_mis;
  logic                      w_unused;

  assign w_req_idx = req_addr[IDX_W+1:2];
  assign w_unused  = ^req_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_req_mis = |req_addr[1:0];
`else
  assign w_req_mis = 1'b0;
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // With LATENCY==1 the commit happens on the acceptance edge, so it reads the live request.
  assign w_commit = (w_accept && (LATENCY == 1)) ||
                    ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));

  always_comb begin
    w_c_write = r_write;
    w_c_idx   = r_idx;
    w_c_wdata = r_wdata;
    w_c_mis   = r_mis;
    if (r_state == S_IDLE) begin
      w_c_write = req_write;
      w_c_idx   = w_req_idx;
      w_c_wdata = req_wdata;
      w_c_mis   = w_req_mis;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == CNT_W'(1)) w_next = S_RESP;
      S_RESP: if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_mis   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_idx   <= w_req_idx;
        r_wdata <= req_wdata;
        r_mis   <= w_req_mis;
        r_cnt   <= CNT_W'(LATENCY - 1);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // Misaligned accesses are suppressed: no write, zero load data.
      if (w_commit) begin
        if (w_c_write && !w_c_mis) r_mem[w_c_idx] <= w_c_wdata;
        r_rdata <= (w_c_write || w_c_mis) ? '0 : r_mem[w_c_idx];
        r_err   <= w_c_mis;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function/backpressure/reset/alias/alignment,
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the LATENCY=2 instance idle.
  task automatic xact(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int hold, output logic [31:0] rdata, output logic err);
    int acc;
    int t;
    logic [31:0] rd0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    check({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    t = 0;
    while (!resp_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_lat"}, cyc + 1 - acc, 32'd2);
    rdata = resp_rdata;
    err   = resp_err;
    rd0   = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_bp_vld"}, {31'b0, resp_valid}, 32'd1);
      check({tag, "_bp_rdata"}, resp_rdata, rd0);
      check({tag, "_bp_rdy"}, {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_idle_rdy"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_idle_vld"}, {31'b0, resp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic        seen;
  int          acc_c [3];
  int          rsp_c [3];
  logic [31:0] rsp_d [3];
  int          na, nr;
  logic        s_acc, s_rv;
  logic [31:0] s_rd;
  logic        b_wr_v [3];
  logic [31:0] b_ad_v [3];
  logic [31:0] b_wd_v [3];
  logic [31:0] b_ex_v [3];

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rdy", {31'b0, req_ready}, 32'd1);
    check("rst_vld", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    check("rst_rdy_l1", {31'b0, b_req_ready}, 32'd1);

    xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("st10_rdata", rd, 32'd0);
    check("st10_err", {31'b0, er}, 32'd0);
    xact("ld10", 1'b0, 32'h10, 32'h0, 0, rd, er);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", {31'b0, er}, 32'd0);
    xact("ld10bp", 1'b0, 32'h10, 32'h0, 5, rd, er);
    check("ld10bp_rdata", rd, 32'hDEADBEEF);

    xact("st04", 1'b1, 32'h4, 32'h12345678, 0, rd, er);
    xact("ld404", 1'b0, 32'h404, 32'h0, 0, rd, er);
    check("alias_rdata", rd, 32'h12345678);

    // Reset while the store sits in WAIT
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_rdy", {31'b0, req_ready}, 32'd1);
    seen = resp_valid;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | resp_valid;
    end
    check("mrst_novld", {31'b0, seen}, 32'd0);
    xact("ld20", 1'b0, 32'h20, 32'h0, 0, rd, er);
    check("mrst_ld20", rd, 32'd0);
    xact("ld10c", 1'b0, 32'h10, 32'h0, 0, rd, er);
    check("mrst_cleared", rd, 32'd0);

    xact("st22", 1'b1, 32'h22, 32'hFFFFFFFF, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    check("st22_err", {31'b0, er}, 32'd1);
    xact("ld20b", 1'b0, 32'h20, 32'h0, 0, rd, er);
    check("ld20b_rdata", rd, 32'd0);
    check("ld20b_err", {31'b0, er}, 32'd0);
    xact("ld22", 1'b0, 32'h22, 32'h0, 0, rd, er);
    check("ld22_err", {31'b0, er}, 32'd1);
    check("ld22_rdata", rd, 32'd0);
`else
    check("st22_err", {31'b0, er}, 32'd0);
    xact("ld20b", 1'b0, 32'h20, 32'h0, 0, rd, er);
    check("ld20b_rdata", rd, 32'hFFFFFFFF);
    check("ld20b_err", {31'b0, er}, 32'd0);
    xact("ld22", 1'b0, 32'h22, 32'h0, 0, rd, er);
    check("ld22_err", {31'b0, er}, 32'd0);
    check("ld22_rdata", rd, 32'hFFFFFFFF);
`endif

    // LATENCY=1 instance: req_valid held high, resp_ready held high
    b_wr_v = '{1'b1, 1'b0, 1'b0};
    b_ad_v = '{32'h8, 32'h8, 32'hC};
    b_wd_v = '{32'hCAFEF00D, 32'h0, 32'h0};
    b_ex_v = '{32'h0, 32'hCAFEF00D, 32'h0};
    na = 0; nr = 0;
    b_resp_ready = 1'b1;
    b_req_valid  = 1'b1;
    b_req_write  = b_wr_v[0]; b_req_addr = b_ad_v[0]; b_req_wdata = b_wd_v[0];
    for (int c = 0; c < 16; c++) begin
      s_acc = b_req_valid & b_req_ready;
      s_rv  = b_resp_valid;
      s_rd  = b_resp_rdata;
      @(posedge clk); #1;
      if (s_acc && na < 3) begin
        acc_c[na] = cyc;
        na++;
        if (na < 3) begin
          b_req_write = b_wr_v[na]; b_req_addr = b_ad_v[na]; b_req_wdata = b_wd_v[na];
        end else begin
          b_req_valid = 1'b0;
        end
      end
      if (s_rv && nr < 3) begin
        rsp_c[nr] = cyc;
        rsp_d[nr] = s_rd;
        nr++;
      end
    end
    check("l1_nacc", na, 32'd3);
    check("l1_nrsp", nr, 32'd3);
    if (na == 3 && nr == 3) begin
      check("l1_gap01", acc_c[1] - acc_c[0], 32'd2);
      check("l1_gap12", acc_c[2] - acc_c[1], 32'd2);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("l1_lat%0d", i), rsp_c[i] - acc_c[i], 32'd1);
        check($sformatf("l1_rdata%0d", i), rsp_d[i], b_ex_v[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
